alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Decode/operand-fetch stage sitting directly upstream of the 8-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake, decodes the ALU opcode, and reads operands from an internal 8x8 register file.
- Presents a registered ALU_control / ALU_srcdata_1 / ALU_srcdata_2 bundle plus a destination tag to the ALU.
- Takes results back through a write-back port; a per-register scoreboard stalls issue on read-after-write hazards.

Parameters:
- DATA_W, 8, operand/register width; must match the ALU width.
- NREGS, 8, register count; fixed by the 3-bit register fields.
- ZERO_REG, 1, when 1, r0 reads as 0 and ignores writes.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  16  instruction word.
- instr_valid  in  1  instr holds a valid instruction.
- instr_ready  out  1  stage accepts instr this cycle (combinational).
- ALU_control  out  4  registered opcode to the ALU.
- ALU_srcdata_1  out  8  registered operand 1.
- ALU_srcdata_2  out  8  registered operand 2 (register value or immediate).
- alu_rd  out  3  destination register tag travelling with the operation.
- alu_valid  out  1  output bundle valid.
- alu_ready  in  1  downstream consumes the bundle.
- wb_en  in  1  write-back strobe.
- wb_addr  in  3  write-back register index.
- wb_data  in  8  write-back value.
- illegal_instr  out  1  one-cycle pulse when an illegal opcode is consumed.

Behaviour:
- Instruction fields:
  - [15:12] op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 LSL, 7 LSR, 8 ASR. Opcode constants are shared with the ALU.
  - [11:9] rd, [8:6] rs1, [5] imm_sel.
  - imm_sel=0: rs2 = [4:2]; [1:0] ignored.
  - imm_sel=1: srcdata_2 = zero-extended [4:0].
- Register file:
  - NREGS x DATA_W; reset clears all entries to 0.
  - One write-back write port; two combinational read ports.
- Bypass: if wb_en is high and wb_addr matches a source index in the same cycle, wb_data is used instead of the stored value. Does not apply to r0 when ZERO_REG=1.
- Scoreboard (pending[NREGS], reset 0):
  - Set pending[rd] on issue of a legal op.
  - Clear pending[wb_addr] on wb_en.
  - Issue and write-back to the same register in the same cycle: set wins.
  - r0 is never marked pending when ZERO_REG=1.
- Hazard: a source is used when it is rs1, or rs2 with imm_sel=0. NOT uses rs1 only. Hazard = any used source pending and not cleared by a same-cycle write-back.
- Output bundle register loads when out_free = (!alu_valid || alu_ready).
- instr_ready = out_free && !hazard.
  - Illegal opcodes (9-15) are consumed whenever out_free, regardless of hazard.
- Transfer occurs when instr_valid && instr_ready.
  - Legal op: bundle loaded and alu_valid=1 on the next cycle (1-cycle latency).
  - Illegal op: nothing issued, scoreboard unchanged, illegal_instr pulses high on the next cycle.
- alu_valid:
  - Clears on alu_ready when no new transfer occurs.
  - Back-to-back transfers are allowed (full throughput when hazard-free).
  - Bundle fields are held stable while alu_valid && !alu_ready.
- Reset values:
  - alu_valid=0, illegal_instr=0, ALU_control=0, srcdata=0, alu_rd=0.
  - Scoreboard and register file cleared.
- Reset mid-operation: an in-flight bundle is dropped, all pending bits are cleared, and a wb_en in the reset cycle is ignored.
- Write-back to a non-pending register is legal and simply updates the register file.

Decomposition:
- Shared package holds:
  - ALU opcode constants (ADD..ASR, 4-bit) and OP_LAST=8.
  - Instruction field bit positions.
  - DATA_W, REG_AW=3.
- One natural sub-module: alu_regfile (2R/1W, reset-clear, bypass, ZERO_REG handling).
- Scoreboard and output register stay in the top module.

Test Plan:
1. Reset, then WB r1=0x05 and r2=0x03; issue ADD r3,r1,r2 with alu_ready=1. Next cycle: alu_valid=1, ALU_control=0, src1=0x05, src2=0x03, alu_rd=3.
2. Issue SUB r4,r3,imm 0x1F while r3 is pending. Required: instr_ready=0 until the cycle WB r3=0x08 arrives. That cycle: ready=1 and bypass gives src1=0x08, src2=0x1F.
3. Hold alu_ready=0 with a bundle valid and a second hazard-free instruction waiting. Required: the bundle stays stable and instr_ready=0. On alu_ready=1 the second bundle appears the next cycle with no bubble.
4. Issue instr 0xF000. Required: consumed with no alu_valid, illegal_instr high for exactly one cycle, scoreboard unchanged.
5. With ZERO_REG=1: WB r0=0xAA, then issue OR r5,r0,r0. Required: src1=src2=0x00, and an rd=r0 issue never stalls later readers of r0.
6. Assert reset while alu_valid=1 with r5 pending. Required: alu_valid=0 next cycle, all registers read 0, and a reader of r5 issues without stall.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared opcodes, field positions and widths for the ALU operand stage
package alu_operand_stage_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int NREGS  = 1 << REG_AW;

  // Opcode values are shared with the ALU; keep them in lockstep.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_LSL = 4'd6,
    OP_LSR = 4'd7,
    OP_ASR = 4'd8
  } alu_op_e;

  localparam logic [3:0] OP_LAST = 4'd8;

  // Instruction field bit positions.
  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 12;
  localparam int RD_MSB      = 11;
  localparam int RD_LSB      = 9;
  localparam int RS1_MSB     = 8;
  localparam int RS1_LSB     = 6;
  localparam int IMM_SEL_BIT = 5;
  localparam int RS2_MSB     = 4;
  localparam int RS2_LSB     = 2;
  localparam int IMM_MSB     = 4;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = IMM_MSB - IMM_LSB + 1;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

  // NOT is unary, so its rs2 field never creates a dependency.
  function automatic logic op_uses_rs2(input logic [3:0] op, input logic imm_sel);
    return !imm_sel && (op != OP_NOT);
  endfunction

endpackage

// File: rtl/alu_operand_stage_regfile.sv
// rtl/alu_operand_stage_regfile.sv - 2-read/1-write register file with write-back bypass
// Ports:
//   clk, reset              : clock, synchronous active-high reset (clears all entries)
//   wr_en/wr_addr/wr_data   : write-back port
//   rd_addr_1/rd_data_1     : combinational read port 1
//   rd_addr_2/rd_data_2     : combinational read port 2
module alu_operand_stage_regfile #(
  parameter int DATA_W   = alu_operand_stage_pkg::DATA_W,
  parameter int NREGS    = alu_operand_stage_pkg::NREGS,
  parameter int AW       = alu_operand_stage_pkg::REG_AW,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  input  logic [AW-1:0]     rd_addr_2,
  output logic [DATA_W-1:0] rd_data_2
);

  logic [DATA_W-1:0] mem [NREGS];
  logic              wr_ok;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  assign wr_ok = wr_en && !is_zero_reg(wr_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Same-cycle write-back is forwarded so a consumer waiting on it can issue now.
  always_comb begin
    rd_data_1 = mem[rd_addr_1];
    if (is_zero_reg(rd_addr_1))                rd_data_1 = '0;
    else if (wr_ok && (wr_addr == rd_addr_1))  rd_data_1 = wr_data;
  end

  always_comb begin
    rd_data_2 = mem[rd_addr_2];
    if (is_zero_reg(rd_addr_2))                rd_data_2 = '0;
    else if (wr_ok && (wr_addr == rd_addr_2))  rd_data_2 = wr_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - decode/operand-fetch stage with RAW scoreboard feeding the ALU
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   instr, instr_valid, instr_ready     : instruction handshake (ready is combinational)
//   ALU_control, ALU_srcdata_1/_2       : registered operation bundle to the ALU
//   alu_rd, alu_valid, alu_ready        : destination tag and bundle handshake
//   wb_en, wb_addr, wb_data             : result write-back
//   illegal_instr                       : one-cycle pulse after an illegal opcode is consumed
module alu_operand_stage #(
  parameter int DATA_W   = alu_operand_stage_pkg::DATA_W,
  parameter int NREGS    = alu_operand_stage_pkg::NREGS,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [15:0]                              instr,
  input  logic                                     instr_valid,
  output logic                                     instr_ready,
  output logic [3:0]                               ALU_control,
  output logic [DATA_W-1:0]                        ALU_srcdata_1,
  output logic [DATA_W-1:0]                        ALU_srcdata_2,
  output logic [alu_operand_stage_pkg::REG_AW-1:0] alu_rd,
  output logic                                     alu_valid,
  input  logic                                     alu_ready,
  input  logic                                     wb_en,
  input  logic [alu_operand_stage_pkg::REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0]                        wb_data,
  output logic                                     illegal_instr
);

  import alu_operand_stage_pkg::*;

  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic              imm_sel;
  logic [IMM_W-1:0]  imm;

  logic [DATA_W-1:0] rf_rd1, rf_rd2, src2_val;
  logic [NREGS-1:0]  pending, pending_eff, wb_clear, issue_set;
  logic              legal, hazard, out_free, fire, issue;

  assign op      = instr[OP_MSB:OP_LSB];
  assign rd      = instr[RD_MSB:RD_LSB];
  assign rs1     = instr[RS1_MSB:RS1_LSB];
  assign imm_sel = instr[IMM_SEL_BIT];
  assign rs2     = instr[RS2_MSB:RS2_LSB];
  assign imm     = instr[IMM_MSB:IMM_LSB];

  alu_operand_stage_regfile #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .AW       (REG_AW),
    .ZERO_REG (ZERO_REG)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_1 (rs1),
    .rd_data_1 (rf_rd1),
    .rd_addr_2 (rs2),
    .rd_data_2 (rf_rd2)
  );

  // A same-cycle write-back retires the dependency, so it is masked out
  // before the hazard check as well as before the next pending value.
  always_comb begin
    wb_clear = '0;
    if (wb_en) wb_clear[wb_addr] = 1'b1;
    pending_eff = pending & ~wb_clear;
  end

  assign legal    = op_is_legal(op);
  // Illegal opcodes never read operands, so they are never held by a hazard.
  assign hazard   = legal && (pending_eff[rs1] ||
                              (op_uses_rs2(op, imm_sel) && pending_eff[rs2]));
  assign out_free = !alu_valid || alu_ready;

  assign instr_ready = out_free && !hazard;
  assign fire        = instr_valid && instr_ready;
  assign issue       = fire && legal;

  assign src2_val = imm_sel ? {{(DATA_W-IMM_W){1'b0}}, imm} : rf_rd2;

  always_comb begin
    issue_set = '0;
    if (issue && !(ZERO_REG && (rd == '0))) issue_set[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_valid     <= 1'b0;
      ALU_control   <= '0;
      ALU_srcdata_1 <= '0;
      ALU_srcdata_2 <= '0;
      alu_rd        <= '0;
      illegal_instr <= 1'b0;
    end else begin
      illegal_instr <= fire && !legal;
      if (out_free) begin
        alu_valid <= issue;
        if (issue) begin
          ALU_control   <= op;
          ALU_srcdata_1 <= rf_rd1;
          ALU_srcdata_2 <= src2_val;
          alu_rd        <= rd;
        end
      end
    end
  end

  // OR after clear: an issue to the register being written back stays pending.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_eff | issue_set;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - randomized self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  ALU_control;
  logic [7:0]  ALU_srcdata_1, ALU_srcdata_2;
  logic [2:0]  alu_rd;
  logic        alu_valid;
  logic        alu_ready = 1'b0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [7:0]  wb_data = '0;
  logic        illegal_instr;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .ALU_control   (ALU_control),
    .ALU_srcdata_1 (ALU_srcdata_1),
    .ALU_srcdata_2 (ALU_srcdata_2),
    .alu_rd        (alu_rd),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .illegal_instr (illegal_instr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural registers, outstanding-result flags, ALU-side bundle.
  logic [7:0] m_regs [8];
  logic       m_pend [8];
  logic       m_valid = 1'b0, m_illegal = 1'b0;
  logic [3:0] m_ctrl = '0;
  logic [7:0] m_src1 = '0, m_src2 = '0;
  logic [2:0] m_rd = '0;

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic imm,
                                      input logic [4:0] lo);
    return {op, rd, rs1, imm, lo};
  endfunction

  // r0 is hard-wired zero; a value being written back this cycle is already visible.
  function automatic logic [7:0] m_read(input logic [2:0] a, input logic we,
                                        input logic [2:0] wa, input logic [7:0] wd);
    if (a == 3'd0) return 8'h00;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [2:0] a, input logic we, input logic [2:0] wa);
    return m_pend[a] && !(we && wa == a);
  endfunction

  task automatic cycle(input logic rst, input logic [15:0] ins, input logic iv,
                       input logic ar, input logic we, input logic [2:0] wa,
                       input logic [7:0] wd, output logic rdy_seen);
    int  op;
    logic legal, free, hz, rdy, fire;
    @(negedge clk);
    reset = rst; instr = ins; instr_valid = iv; alu_ready = ar;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    op    = int'(ins[15:12]);
    legal = (op <= 8);
    free  = !m_valid || ar;
    hz    = legal && (m_busy(ins[8:6], we, wa) ||
                      (!ins[5] && op != 5 && m_busy(ins[4:2], we, wa)));
    rdy   = free && !hz;
    rdy_seen = instr_ready;
    if (!rst) check_value("instr_ready", {15'd0, instr_ready}, {15'd0, rdy});
    fire = iv && rdy;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_regs[i] = 8'h00; m_pend[i] = 1'b0; end
      m_valid = 0; m_illegal = 0; m_ctrl = 0; m_src1 = 0; m_src2 = 0; m_rd = 0;
    end else begin
      if (free) begin
        m_valid = fire && legal;
        if (fire && legal) begin
          m_ctrl = ins[15:12];
          m_src1 = m_read(ins[8:6], we, wa, wd);
          m_src2 = ins[5] ? {3'b000, ins[4:0]} : m_read(ins[4:2], we, wa, wd);
          m_rd   = ins[11:9];
        end
      end
      m_illegal = fire && !legal;
      if (we) begin
        if (wa != 3'd0) m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (fire && legal && ins[11:9] != 3'd0) m_pend[ins[11:9]] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_value("alu_valid", {15'd0, alu_valid}, {15'd0, m_valid});
    check_value("illegal_instr", {15'd0, illegal_instr}, {15'd0, m_illegal});
    if (m_valid || rst) begin
      check_value("ALU_control", {12'd0, ALU_control}, {12'd0, m_ctrl});
      check_value("ALU_srcdata_1", {8'd0, ALU_srcdata_1}, {8'd0, m_src1});
      check_value("ALU_srcdata_2", {8'd0, ALU_srcdata_2}, {8'd0, m_src2});
      check_value("alu_rd", {13'd0, alu_rd}, {13'd0, m_rd});
    end
  endtask

  initial begin
    logic        r;
    logic [3:0]  op;
    for (int i = 0; i < 8; i++) begin m_regs[i] = 8'h00; m_pend[i] = 1'b0; end

    cycle(1, 16'h0, 0, 0, 0, 3'd0, 8'h00, r);
    cycle(1, 16'h0, 0, 0, 0, 3'd0, 8'h00, r);

    // Write-back r1, r2 then ADD r3,r1,r2.
    cycle(0, 16'h0, 0, 1, 1, 3'd1, 8'h05, r);
    cycle(0, 16'h0, 0, 1, 1, 3'd2, 8'h03, r);
    cycle(0, enc(4'd0, 3'd3, 3'd1, 1'b0, {3'd2, 2'b00}), 1, 1, 0, 3'd0, 8'h00, r);
    check_value("t1_valid", {15'd0, alu_valid}, 16'd1);
    check_value("t1_src1", {8'd0, ALU_srcdata_1}, 16'h05);
    check_value("t1_src2", {8'd0, ALU_srcdata_2}, 16'h03);
    check_value("t1_rd", {13'd0, alu_rd}, 16'd3);

    // SUB r4,r3,#0x1F stalls on r3 until its write-back arrives, then bypasses.
    cycle(0, enc(4'd1, 3'd4, 3'd3, 1'b1, 5'h1F), 1, 1, 0, 3'd0, 8'h00, r);
    check_value("t2_stall", {15'd0, r}, 16'd0);
    cycle(0, enc(4'd1, 3'd4, 3'd3, 1'b1, 5'h1F), 1, 1, 1, 3'd3, 8'h08, r);
    check_value("t2_ready", {15'd0, r}, 16'd1);
    check_value("t2_src1", {8'd0, ALU_srcdata_1}, 16'h08);
    check_value("t2_src2", {8'd0, ALU_srcdata_2}, 16'h1F);

    // Backpressure: bundle held, AND r6,r1,r2 waits, then follows with no bubble.
    for (int k = 0; k < 2; k++) begin
      cycle(0, enc(4'd2, 3'd6, 3'd1, 1'b0, {3'd2, 2'b00}), 1, 0, 0, 3'd0, 8'h00, r);
      check_value("t3_hold_ready", {15'd0, r}, 16'd0);
      check_value("t3_hold_src1", {8'd0, ALU_srcdata_1}, 16'h08);
    end
    cycle(0, enc(4'd2, 3'd6, 3'd1, 1'b0, {3'd2, 2'b00}), 1, 1, 0, 3'd0, 8'h00, r);
    check_value("t3_next_valid", {15'd0, alu_valid}, 16'd1);
    check_value("t3_next_ctrl", {12'd0, ALU_control}, 16'd2);

    // Illegal opcode.
    cycle(0, 16'hF000, 1, 1, 0, 3'd0, 8'h00, r);
    check_value("t4_illegal", {15'd0, illegal_instr}, 16'd1);
    check_value("t4_novalid", {15'd0, alu_valid}, 16'd0);
    cycle(0, 16'h0, 0, 1, 0, 3'd0, 8'h00, r);
    check_value("t4_pulse_end", {15'd0, illegal_instr}, 16'd0);

    // r0 ignores writes and is never pending.
    cycle(0, 16'h0, 0, 1, 1, 3'd0, 8'hAA, r);
    cycle(0, enc(4'd3, 3'd5, 3'd0, 1'b0, {3'd0, 2'b00}), 1, 1, 0, 3'd0, 8'h00, r);
    check_value("t5_src1", {8'd0, ALU_srcdata_1}, 16'h00);
    check_value("t5_src2", {8'd0, ALU_srcdata_2}, 16'h00);
    cycle(0, enc(4'd0, 3'd0, 3'd1, 1'b0, {3'd1, 2'b00}), 1, 1, 0, 3'd0, 8'h00, r);
    cycle(0, enc(4'd0, 3'd7, 3'd0, 1'b0, {3'd0, 2'b00}), 1, 1, 0, 3'd0, 8'h00, r);
    check_value("t5_r0_nostall", {15'd0, r}, 16'd1);

    // Reset mid-flight with r5 pending and a write-back in the reset cycle.
    cycle(1, 16'h0, 0, 0, 1, 3'd1, 8'h55, r);
    check_value("t6_valid", {15'd0, alu_valid}, 16'd0);
    cycle(0, enc(4'd0, 3'd2, 3'd5, 1'b0, {3'd1, 2'b00}), 1, 1, 0, 3'd0, 8'h00, r);
    check_value("t6_nostall", {15'd0, r}, 16'd1);
    check_value("t6_src1", {8'd0, ALU_srcdata_1}, 16'h00);
    check_value("t6_src2", {8'd0, ALU_srcdata_2}, 16'h00);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      op = 4'($urandom_range(0, 11));
      if (op > 4'd8) op = 4'($urandom_range(9, 15));
      cycle(($urandom_range(0, 99) == 0),
            {op, 12'($urandom)},
            1'($urandom),
            ($urandom_range(0, 3) != 0),
            1'($urandom),
            3'($urandom),
            8'($urandom), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
